// File: rtl/vga_pixel_formatter.sv
// VGA DAC output stage: per-channel quantisation, blanking, sync polarity
// and measurement of the incoming video timing with a lock flag.
module vga_pixel_formatter #(
    parameter int RW     = 5,
    parameter int GW     = 6,
    parameter int BW     = 5,
    parameter int MODE   = 0,
    parameter int HS_INV = 0,
    parameter int VS_INV = 0,
    parameter int CNT_W  = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_hsync,
    input  logic             in_vsync,
    input  logic             in_de,
    input  logic [7:0]       in_red,
    input  logic [7:0]       in_green,
    input  logic [7:0]       in_blue,
    output logic             out_hsync,
    output logic             out_vsync,
    output logic             out_de,
    output logic [RW-1:0]    out_red,
    output logic [GW-1:0]    out_green,
    output logic [BW-1:0]    out_blue,
    output logic [CNT_W-1:0] meas_htotal,
    output logic [CNT_W-1:0] meas_hact,
    output logic [CNT_W-1:0] meas_vtotal,
    output logic [CNT_W-1:0] meas_vact,
    output logic             meas_valid,
    output logic             locked
);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_VALID} state_t;

    localparam logic [CNT_W-1:0] CMAX = '1;

    logic             s1_hsync, s1_vsync, s1_de;
    logic             s1_x0, s1_y0;
    logic [7:0]       s1_red, s1_green, s1_blue;
    logic [CNT_W-1:0] x_cnt, y_cnt, h_cnt, v_cnt;
    logic [CNT_W-1:0] h_sh_total, h_sh_act;
    logic [CNT_W-1:0] total_nxt, act_nxt, vt_nxt, va_nxt;
    logic             hs_rise, vs_rise, de_fall, sat;
    logic             upd, cmp;
    state_t           state, state_nxt;
    logic [1:0]       bayer;
    logic [7:0]       q_red, q_green, q_blue;

    // Stage-1 registers double as the previous-cycle samples for edges.
    assign hs_rise = in_hsync & ~s1_hsync;
    assign vs_rise = in_vsync & ~s1_vsync;
    assign de_fall = ~in_de & s1_de;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_hsync <= 1'b0;
            s1_vsync <= 1'b0;
            s1_de    <= 1'b0;
            s1_red   <= '0;
            s1_green <= '0;
            s1_blue  <= '0;
            s1_x0    <= 1'b0;
            s1_y0    <= 1'b0;
        end else begin
            s1_hsync <= in_hsync;
            s1_vsync <= in_vsync;
            s1_de    <= in_de;
            s1_red   <= in_red;
            s1_green <= in_green;
            s1_blue  <= in_blue;
            s1_x0    <= x_cnt[0];
            s1_y0    <= y_cnt[0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_cnt      <= '0;
            y_cnt      <= '0;
            h_cnt      <= '0;
            v_cnt      <= '0;
            h_sh_total <= '0;
            h_sh_act   <= '0;
        end else begin
            if (!in_de)
                x_cnt <= '0;
            else if (x_cnt != CMAX)
                x_cnt <= x_cnt + 1'b1;
            y_cnt      <= vs_rise ? '0 : va_nxt;
            v_cnt      <= vs_rise ? '0 : vt_nxt;
            h_sh_total <= total_nxt;
            h_sh_act   <= act_nxt;
            if (hs_rise)
                h_cnt <= '0;
            else if (h_cnt != CMAX)
                h_cnt <= h_cnt + 1'b1;
        end
    end

    // Next values include same-cycle edges so a closing frame sees them.
    assign total_nxt = !hs_rise ? h_sh_total :
                       (h_cnt == CMAX) ? CMAX : h_cnt + 1'b1;
    assign act_nxt   = de_fall ? x_cnt : h_sh_act;
    assign vt_nxt    = (hs_rise && v_cnt != CMAX) ? v_cnt + 1'b1 : v_cnt;
    assign va_nxt    = (de_fall && y_cnt != CMAX) ? y_cnt + 1'b1 : y_cnt;

    assign sat = ((h_cnt == CMAX) && !hs_rise) ||
                 ((v_cnt == CMAX) && hs_rise);

    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (sat) begin
            state_nxt = S_IDLE;
        end else if (vs_rise) begin
            unique case (state)
                S_IDLE:           state_nxt = S_ARMED;
                S_ARMED, S_VALID: state_nxt = S_VALID;
                default:          state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        upd = 1'b0;
        cmp = 1'b0;
        if (vs_rise && !sat) begin
            upd = (state != S_IDLE);
            cmp = (state == S_VALID);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meas_htotal <= '0;
            meas_hact   <= '0;
            meas_vtotal <= '0;
            meas_vact   <= '0;
            meas_valid  <= 1'b0;
            locked      <= 1'b0;
        end else if (sat) begin
            meas_valid <= 1'b0;
            locked     <= 1'b0;
        end else if (upd) begin
            meas_htotal <= total_nxt;
            meas_hact   <= act_nxt;
            meas_vtotal <= vt_nxt;
            meas_vact   <= va_nxt;
            meas_valid  <= 1'b1;
            locked      <= cmp &&
                ({total_nxt, act_nxt, vt_nxt, va_nxt} ==
                 {meas_htotal, meas_hact, meas_vtotal, meas_vact});
        end
    end

    // Result is left-aligned; the caller keeps the top w bits.
    function automatic logic [7:0] quant(input logic [7:0] v,
                                         input int w,
                                         input logic [1:0] b);
        logic [8:0] sum;
        sum = {1'b0, v};
        if (w < 8) begin
            if (MODE == 1)
                sum = sum + (9'd1 << (7 - w));
            else if (MODE == 2)
                sum = sum + ((9'(b) << (8 - w)) >> 2);
        end
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    // 2x2 Bayer: row y=0 -> {0,2}, row y=1 -> {3,1}.
    assign bayer   = {s1_x0 ^ s1_y0, s1_y0};
    assign q_red   = quant(s1_red, RW, bayer);
    assign q_green = quant(s1_green, GW, bayer);
    assign q_blue  = quant(s1_blue, BW, bayer);

    always_ff @(posedge clk) begin
        if (reset) begin
            out_hsync <= 1'(HS_INV);
            out_vsync <= 1'(VS_INV);
            out_de    <= 1'b0;
            out_red   <= '0;
            out_green <= '0;
            out_blue  <= '0;
        end else begin
            out_hsync <= s1_hsync ^ 1'(HS_INV);
            out_vsync <= s1_vsync ^ 1'(VS_INV);
            out_de    <= s1_de;
            out_red   <= s1_de ? RW'(q_red >> (8 - RW)) : '0;
            out_green <= s1_de ? GW'(q_green >> (8 - GW)) : '0;
            out_blue  <= s1_de ? BW'(q_blue >> (8 - BW)) : '0;
        end
    end

endmodule

// File: tb/tb_vga_pixel_formatter.sv
// Bench for vga_pixel_formatter: three instances (truncate, round,
// dither with inverted syncs) against an arithmetic reference model.
module tb_vga_pixel_formatter;

    localparam int HT = 40;
    localparam int HA = 32;
    localparam int VT = 20;
    localparam int VA = 15;
    localparam int MD[3]  = '{0, 1, 2};
    localparam int INV[3] = '{0, 0, 1};
    localparam int W_R[3] = '{5, 5, 5};
    localparam int W_G[3] = '{6, 6, 6};
    localparam int W_B[3] = '{5, 3, 8};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, in_hsync, in_vsync, in_de;
    logic [7:0] in_red, in_green, in_blue;

    logic        o_hs[3], o_vs[3], o_de[3];
    logic [11:0] m_ht[3], m_ha[3], m_vt[3], m_va[3];
    logic        m_valid[3], m_lock[3];
    logic [4:0]  o0_r, o0_b, o1_r, o2_r;
    logic [5:0]  o0_g, o1_g, o2_g;
    logic [2:0]  o1_b;
    logic [7:0]  o2_b;

    vga_pixel_formatter #(.RW(5), .GW(6), .BW(5), .MODE(0)) u0 (
        .clk(clk), .reset(reset),
        .in_hsync(in_hsync), .in_vsync(in_vsync), .in_de(in_de),
        .in_red(in_red), .in_green(in_green), .in_blue(in_blue),
        .out_hsync(o_hs[0]), .out_vsync(o_vs[0]), .out_de(o_de[0]),
        .out_red(o0_r), .out_green(o0_g), .out_blue(o0_b),
        .meas_htotal(m_ht[0]), .meas_hact(m_ha[0]),
        .meas_vtotal(m_vt[0]), .meas_vact(m_va[0]),
        .meas_valid(m_valid[0]), .locked(m_lock[0]));

    vga_pixel_formatter #(.RW(5), .GW(6), .BW(3), .MODE(1)) u1 (
        .clk(clk), .reset(reset),
        .in_hsync(in_hsync), .in_vsync(in_vsync), .in_de(in_de),
        .in_red(in_red), .in_green(in_green), .in_blue(in_blue),
        .out_hsync(o_hs[1]), .out_vsync(o_vs[1]), .out_de(o_de[1]),
        .out_red(o1_r), .out_green(o1_g), .out_blue(o1_b),
        .meas_htotal(m_ht[1]), .meas_hact(m_ha[1]),
        .meas_vtotal(m_vt[1]), .meas_vact(m_va[1]),
        .meas_valid(m_valid[1]), .locked(m_lock[1]));

    vga_pixel_formatter #(.RW(5), .GW(6), .BW(8), .MODE(2),
                          .HS_INV(1), .VS_INV(1)) u2 (
        .clk(clk), .reset(reset),
        .in_hsync(in_hsync), .in_vsync(in_vsync), .in_de(in_de),
        .in_red(in_red), .in_green(in_green), .in_blue(in_blue),
        .out_hsync(o_hs[2]), .out_vsync(o_vs[2]), .out_de(o_de[2]),
        .out_red(o2_r), .out_green(o2_g), .out_blue(o2_b),
        .meas_htotal(m_ht[2]), .meas_hact(m_ha[2]),
        .meas_vtotal(m_vt[2]), .meas_vact(m_va[2]),
        .meas_valid(m_valid[2]), .locked(m_lock[2]));

    typedef struct {
        bit rst, hs, vs, de;
        int r, g, b, x, y;
    } rec_t;

    typedef struct {
        bit       de;
        int       v;
        int       e0;
        int       e1;
    } tv_t;

    int   n_vec = 0;
    int   n_bad = 0;
    rec_t prv;
    int   mx, my;
    bit   pde, pvs;
    int   nrise;
    int   e_ht, e_ha, e_vt, e_va;
    bit   e_valid, e_lock;
    int   cl_ht, cl_ha, cl_vt, cl_va;

    task automatic check(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic int ref_q(input int v, input int w, input int mode,
                                 input int x0, input int y0);
        int lsb, mxv, r;
        int bay[2][2];
        bay = '{'{0, 2}, '{3, 1}};
        if (w == 8) return v;
        lsb = 1 << (8 - w);
        mxv = (1 << w) - 1;
        case (mode)
            0:       r = v / lsb;
            1:       r = (v + lsb / 2) / lsb;
            default: r = (v + bay[y0][x0] * lsb / 4) / lsb;
        endcase
        return (r > mxv) ? mxv : r;
    endfunction

    function automatic int pack(input int hs, input int vs, input int de,
                                input int r, input int g, input int b);
        return (hs << 26) | (vs << 25) | (de << 24) |
               (r << 16) | (g << 8) | b;
    endfunction

    task automatic drive(input bit hs, input bit vs, input bit de,
                         input int r, input int g, input int b);
        in_hsync = hs;
        in_vsync = vs;
        in_de    = de;
        in_red   = 8'(r);
        in_green = 8'(g);
        in_blue  = 8'(b);
    endtask

    task automatic step();
        rec_t cur;
        int   exp, got, er, eg, eb;
        cur.rst = reset;
        cur.hs  = in_hsync;
        cur.vs  = in_vsync;
        cur.de  = in_de;
        cur.r   = int'(in_red);
        cur.g   = int'(in_green);
        cur.b   = int'(in_blue);
        cur.x   = mx;
        cur.y   = my;
        if (reset) begin
            mx = 0; my = 0; pde = 0; pvs = 0;
            nrise = 0;
            e_ht = 0; e_ha = 0; e_vt = 0; e_va = 0;
            e_valid = 0; e_lock = 0;
        end else begin
            if (in_vsync && !pvs) my = 0;
            else if (!in_de && pde) my++;
            if (in_de) mx++;
            else mx = 0;
            pde = in_de;
            pvs = in_vsync;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (cur.rst || prv.rst) begin
                exp = pack(INV[i], INV[i], 0, 0, 0, 0);
            end else begin
                er = prv.de ? ref_q(prv.r, W_R[i], MD[i], prv.x & 1, prv.y & 1) : 0;
                eg = prv.de ? ref_q(prv.g, W_G[i], MD[i], prv.x & 1, prv.y & 1) : 0;
                eb = prv.de ? ref_q(prv.b, W_B[i], MD[i], prv.x & 1, prv.y & 1) : 0;
                exp = pack(int'(prv.hs) ^ INV[i], int'(prv.vs) ^ INV[i],
                           int'(prv.de), er, eg, eb);
            end
            case (i)
                0: got = pack(o_hs[0], o_vs[0], o_de[0], o0_r, o0_g, o0_b);
                1: got = pack(o_hs[1], o_vs[1], o_de[1], o1_r, o1_g, o1_b);
                default: got = pack(o_hs[2], o_vs[2], o_de[2], o2_r, o2_g, o2_b);
            endcase
            check($sformatf("video u%0d", i), got, exp);
        end
        prv = cur;
    endtask

    task automatic check_meas(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s htotal u%0d", tag, i), m_ht[i], e_ht);
            check($sformatf("%s hact u%0d", tag, i), m_ha[i], e_ha);
            check($sformatf("%s vtotal u%0d", tag, i), m_vt[i], e_vt);
            check($sformatf("%s vact u%0d", tag, i), m_va[i], e_va);
            check($sformatf("%s valid u%0d", tag, i), m_valid[i], e_valid);
            check($sformatf("%s locked u%0d", tag, i), m_lock[i], e_lock);
        end
    endtask

    // Frame-level expectation: what a vsync rise should publish.
    task automatic vs_event();
        nrise++;
        if (nrise == 2) begin
            e_ht = cl_ht; e_ha = cl_ha; e_vt = cl_vt; e_va = cl_va;
            e_valid = 1;
            e_lock  = 0;
        end else if (nrise >= 3) begin
            e_lock = (cl_ht == e_ht) && (cl_ha == e_ha) &&
                     (cl_vt == e_vt) && (cl_va == e_va);
            e_ht = cl_ht; e_ha = cl_ha; e_vt = cl_vt; e_va = cl_va;
        end
    endtask

    task automatic run_frame(input int last_len, input int rst_line);
        int  len;
        bit  de;
        for (int l = 0; l < VT; l++) begin
            len = (l == VT - 1) ? last_len : HT;
            for (int p = 0; p < len; p++) begin
                de = (l >= 3) && (l < 3 + VA) && (p >= 6) && (p < 6 + HA);
                drive(p < 4, l < 2, de, $urandom_range(0, 255),
                      $urandom_range(0, 255), $urandom_range(0, 255));
                if (l == rst_line && p == 10) begin
                    reset = 1'b1;
                    step();
                    reset = 1'b0;
                    check_meas("reset mid-line");
                end else begin
                    step();
                end
                if (l == 0 && p == 0) begin
                    vs_event();
                    check_meas($sformatf("vsync rise %0d", nrise));
                end
            end
        end
        check_meas("frame hold");
        cl_ht = last_len; cl_ha = HA; cl_vt = VT; cl_va = VA;
    endtask

    task automatic dither_seq(input int v, input int e00, input int e10,
                              input int e01, input int e11);
        drive(0, 1, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0); step();
        drive(0, 0, 1, 0, v, 0); step();
        step();
        check("dither x0y0", o2_g, e00);
        drive(0, 0, 0, 0, 0, 0); step();
        check("dither x1y0", o2_g, e10);
        drive(0, 0, 1, 0, v, 0); step();
        step();
        check("dither x0y1", o2_g, e01);
        drive(0, 0, 0, 0, 0, 0); step();
        check("dither x1y1", o2_g, e11);
    endtask

    initial begin
        tv_t tbl[8];
        int  lows, first;
        tbl[0] = '{1'b1, 8'hFF, 5'h1F, 5'h1F};
        tbl[1] = '{1'b0, 8'hFF, 5'h00, 5'h00};
        tbl[2] = '{1'b1, 8'h0C, 5'h01, 5'h02};
        tbl[3] = '{1'b1, 8'hFE, 5'h1F, 5'h1F};
        tbl[4] = '{1'b1, 8'h80, 5'h10, 5'h10};
        tbl[5] = '{1'b1, 8'h07, 5'h00, 5'h01};
        tbl[6] = '{1'b1, 8'hF8, 5'h1F, 5'h1F};
        tbl[7] = '{1'b1, 8'h03, 5'h00, 5'h00};

        prv.rst = 1'b1;
        mx = 0; my = 0; pde = 0; pvs = 0; nrise = 0;
        cl_ht = 0; cl_ha = 0; cl_vt = 0; cl_va = 0;
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        repeat (3) step();
        check_meas("reset");
        check("reset out_hsync inverted", o_hs[2], 1);
        check("reset out_vsync inverted", o_vs[2], 1);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            drive(0, 0, tbl[i].de, tbl[i].v, tbl[i].v, tbl[i].v);
            repeat (3) step();
            check($sformatf("table %0d trunc red", i), o0_r, tbl[i].e0);
            check($sformatf("table %0d round red", i), o1_r, tbl[i].e1);
        end

        dither_seq(8'h01, 0, 0, 1, 0);
        dither_seq(8'hFF, 6'h3F, 6'h3F, 6'h3F, 6'h3F);

        lows = 0;
        first = -1;
        for (int k = 0; k < 100; k++) begin
            drive(k < 96, 0, 0, 0, 0, 0);
            step();
            if (o_hs[2] == 1'b0) begin
                lows++;
                if (first < 0) first = k + 1;
            end
        end
        check("hsync pulse width", lows, 96);
        check("hsync pulse delay", first, 2);

        for (int k = 0; k < 300; k++) begin
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                  1'($urandom_range(0, 1)), $urandom_range(0, 255),
                  $urandom_range(0, 255), $urandom_range(0, 255));
            step();
        end

        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) step();
        reset = 1'b0;
        check_meas("reset again");

        for (int f = 0; f < 7; f++)
            run_frame((f == 3) ? HT + 1 : HT, -1);

        drive(0, 0, 0, 0, 0, 0);
        repeat (4200) step();
        nrise = 0;
        e_valid = 0;
        e_lock = 0;
        check_meas("sync loss");
        for (int f = 0; f < 3; f++)
            run_frame(HT, -1);

        run_frame(HT, 5);
        run_frame(HT, -1);
        run_frame(HT, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
